// File: rtl/scan_select_seq.sv
// -----------------------------------------------------------------------------
// scan_select_seq
//
// Drives one half of a 74x139-style 2-to-4 active-low decoder so that four
// loads can be time-multiplexed. The enabled slots are visited in ascending
// cyclic order. Each slot gets BLANK cycles with the decoder disabled,
// followed by DWELL cycles with the decoder enabled. The address (a/b) only
// changes while g_l is high, so the Y_L strobes never glitch or overlap.
//
// Parameters
//   DWELL   cycles g_l is low per slot        (1 .. 2**CNT_W)
//   BLANK   cycles g_l is high before a slot  (1 .. 2**CNT_W)
//   CNT_W   width of the dwell/blank counter
//
// Ports
//   clk      in   system clock, rising edge
//   reset_l  in   asynchronous active-low reset
//   en       in   run request, sampled every cycle
//   mask     in   [3:0] slot enables, bit n includes slot n
//   a        out  decoder select MSB (slot bit 1)
//   b        out  decoder select LSB (slot bit 0)
//   g_l      out  decoder enable, active low
//   slot     out  [1:0] current slot index, equal to {a,b}
//   frame    out  one-cycle pulse in the first blank cycle after a wrap
// -----------------------------------------------------------------------------
module scan_select_seq #(
  parameter int DWELL = 16,
  parameter int BLANK = 2,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       en,
  input  logic [3:0] mask,
  output logic       a,
  output logic       b,
  output logic       g_l,
  output logic [1:0] slot,
  output logic       frame
);

  // The counter is loaded with length-1 and counts down to zero, so a
  // length of 2**CNT_W still fits in CNT_W bits.
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       slot_reg, slot_next;
  logic             g_l_reg, g_l_next;
  logic             frame_reg, frame_next;

  logic [1:0]       first_slot;
  logic [1:0]       next_slot;
  logic [1:0]       cand;

  // Slot search. first_slot is the lowest enabled slot (used when leaving
  // IDLE). next_slot searches upward from slot_reg+1, wrapping; the last
  // candidate (k=4) is slot_reg itself, which covers the single-slot case.
  // Iterating from the far end and overwriting leaves the nearest match.
  always_comb begin
    first_slot = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) first_slot = 2'(i);
    end
    next_slot = slot_reg;
    cand      = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = slot_reg + 2'(k);
      if (mask[cand]) next_slot = cand;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    slot_next  = slot_reg;
    g_l_next   = 1'b1;
    frame_next = 1'b0;

    if (!en) begin
      // Abort from any state: decoder off, address held, no frame pulse.
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|mask) begin
            slot_next  = first_slot;
            cnt_next   = BLANK_LD;
            state_next = ST_BLANK;
          end
        end
        ST_BLANK: begin
          if (cnt_reg == '0) begin
            cnt_next   = DWELL_LD;
            g_l_next   = 1'b0;
            state_next = ST_ACTIVE;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (cnt_reg == '0) begin
            // End of dwell: mask is sampled here only. g_l returns high on
            // the same edge the address moves.
            if (|mask) begin
              slot_next  = next_slot;
              frame_next = (next_slot <= slot_reg);
              cnt_next   = BLANK_LD;
              state_next = ST_BLANK;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            g_l_next = 1'b0;
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      slot_reg  <= 2'd0;
      g_l_reg   <= 1'b1;
      frame_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      slot_reg  <= slot_next;
      g_l_reg   <= g_l_next;
      frame_reg <= frame_next;
    end
  end

  assign a     = slot_reg[1];
  assign b     = slot_reg[0];
  assign slot  = slot_reg;
  assign g_l   = g_l_reg;
  assign frame = frame_reg;

endmodule

// File: tb/tb_scan_select_seq.sv
// -----------------------------------------------------------------------------
// tb_scan_select_seq
//
// Directed bench for scan_select_seq with DWELL=4, BLANK=1 (slot period 5).
// Expected values come from hand-derived timing: after the starting edge the
// sample index c gives the slot as seq[(c/5) mod n], g_l high when c mod 5 is
// 0, and frame high on those blank cycles that return to the first slot.
// -----------------------------------------------------------------------------
module tb_scan_select_seq;

  logic       clk;
  logic       reset_l;
  logic       en;
  logic [3:0] mask;
  logic       a;
  logic       b;
  logic       g_l;
  logic [1:0] slot;
  logic       frame;

  int checks = 0;
  int errors = 0;

  scan_select_seq #(
    .DWELL(4),
    .BLANK(1),
    .CNT_W(8)
  ) dut (
    .clk    (clk),
    .reset_l(reset_l),
    .en     (en),
    .mask   (mask),
    .a      (a),
    .b      (b),
    .g_l    (g_l),
    .slot   (slot),
    .frame  (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Glitch monitor: whenever the address has moved since the last sample,
  // the decoder must be disabled now.
  logic [1:0] prev_ab = 2'b00;
  always @(negedge clk) begin
    if ({a, b} !== prev_ab) chk("glitch_g_l", {31'd0, g_l}, 32'd1);
    prev_ab <= {a, b};
  end

  // Start from IDLE with mask m and check `cycles` samples.
  // seq holds slot indices packed 2 bits each, n of them in visiting order.
  task automatic run_scan(input string tag, input logic [3:0] m,
                          input logic [7:0] seq, input int n, input int cycles);
    logic [1:0] exp_slot;
    int idx;
    en = 1'b0;
    step();
    mask = m;
    en   = 1'b1;
    step();
    for (int c = 0; c < cycles; c++) begin
      idx      = (c / 5) % n;
      exp_slot = seq[idx*2 +: 2];
      chk({tag, "_slot"},  {30'd0, slot}, {30'd0, exp_slot});
      chk({tag, "_ab"},    {30'd0, a, b}, {30'd0, exp_slot});
      chk({tag, "_g_l"},   {31'd0, g_l},  {31'd0, (c % 5 == 0)});
      chk({tag, "_frame"}, {31'd0, frame},
          {31'd0, ((c % 5 == 0) && (c > 0) && (idx == 0))});
      step();
    end
    $display("scan %s mask=%b cycles=%0d checks=%0d errors=%0d", tag, m, cycles, checks, errors);
  endtask

  initial begin
    reset_l = 1'b0;
    en      = 1'b0;
    mask    = 4'b0000;
    #12;
    chk("rst_g_l",   {31'd0, g_l},   32'd1);
    chk("rst_slot",  {30'd0, slot},  32'd0);
    chk("rst_ab",    {30'd0, a, b},  32'd0);
    chk("rst_frame", {31'd0, frame}, 32'd0);
    reset_l = 1'b1;
    $display("reset checked g_l=%0d slot=%0d frame=%0d", g_l, slot, frame);

    // EN low with a mask set: must stay idle.
    mask = 4'b1111;
    step();
    step();
    chk("idle_en0_g_l", {31'd0, g_l}, 32'd1);

    run_scan("full",   4'b1111, 8'b11_10_01_00, 4, 45);
    run_scan("masked", 4'b1010, 8'b00_00_11_01, 2, 25);
    run_scan("single", 4'b0100, 8'b00_00_00_10, 1, 15);

    // Abort during slot 2, dwell cycle 2 (samples c=10 blank, 11, 12 dwell).
    en = 1'b0;
    step();
    mask = 4'b1111;
    en   = 1'b1;
    for (int c = 0; c < 13; c++) step();
    chk("abort_pre_slot", {30'd0, slot}, 32'd2);
    chk("abort_pre_g_l",  {31'd0, g_l},  32'd0);
    en = 1'b0;
    step();
    chk("abort_g_l",   {31'd0, g_l},   32'd1);
    chk("abort_slot",  {30'd0, slot},  32'd2);
    chk("abort_frame", {31'd0, frame}, 32'd0);
    step();
    chk("abort_hold_g_l",  {31'd0, g_l},  32'd1);
    chk("abort_hold_slot", {30'd0, slot}, 32'd2);
    $display("abort g_l=%0d slot=%0d frame=%0d", g_l, slot, frame);

    // Re-raise: restart at the lowest enabled slot, not the held one.
    en = 1'b1;
    step();
    chk("restart_slot", {30'd0, slot}, 32'd0);
    chk("restart_g_l",  {31'd0, g_l},  32'd1);
    step();
    chk("restart_dwell_g_l", {31'd0, g_l}, 32'd0);
    $display("restart slot=%0d g_l=%0d", slot, g_l);

    // Clear mask during dwell cycle 1: dwell still runs 4 cycles, then idle.
    mask = 4'b0000;
    for (int c = 2; c <= 4; c++) begin
      step();
      chk("mask0_dwell_g_l", {31'd0, g_l}, 32'd0);
    end
    step();
    chk("mask0_end_g_l",   {31'd0, g_l},   32'd1);
    chk("mask0_end_slot",  {30'd0, slot},  32'd0);
    chk("mask0_end_frame", {31'd0, frame}, 32'd0);
    step();
    step();
    chk("mask0_idle_g_l", {31'd0, g_l}, 32'd1);
    mask = 4'b0010;
    step();
    chk("mask0_resume_slot", {30'd0, slot}, 32'd1);
    $display("mask0 idle then resume slot=%0d", slot);

    // Async reset mid-ACTIVE in slot 2, applied between edges.
    run_scan("pre_rst", 4'b1111, 8'b11_10_01_00, 4, 12);
    chk("pre_rst_g_l", {31'd0, g_l}, 32'd0);
    #3;
    reset_l = 1'b0;
    #1;
    chk("arst_g_l",   {31'd0, g_l},   32'd1);
    chk("arst_ab",    {30'd0, a, b},  32'd0);
    chk("arst_frame", {31'd0, frame}, 32'd0);
    #2;
    reset_l = 1'b1;
    step();
    chk("arst_rel_slot", {30'd0, slot}, 32'd0);
    chk("arst_rel_g_l",  {31'd0, g_l},  32'd1);
    step();
    chk("arst_first_low", {31'd0, g_l}, 32'd0);
    $display("async reset released, first low g_l=%0d", g_l);

    en = 1'b0;
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_select_seq.md
# scan_select_seq

Sequential address/enable generator that drives a 2-to-4 active-low decoder (74x139-style, one half) to time-multiplex four loads: display digits, LED columns or chip selects. It steps through the enabled slots in ascending cyclic order, holding each slot selected for a programmable dwell. It inserts a blanking gap before every slot so the decoder address only changes while the decoder enable is inactive, giving glitch-free, non-overlapping Y_L strobes. Outputs A, B, G_L connect one-to-one to the decoder inputs of the same names.

## Interface
- DWELL, default 16: cycles G_L is held low per slot; legal range 1..2^CNT_W.
- BLANK, default 2: cycles G_L is held high before each slot; legal range 1..2^CNT_W.
- CNT_W, default 8: width of the internal cycle counter.

- CLK  input  1  system clock, all state updates on rising edge.
- RESET_L  input  1  asynchronous, active-low reset.
- EN  input  1  run request; sampled every cycle.
- MASK  input  4  slot enables, bit n = 1 includes slot n in the scan.
- A  output  1  decoder select MSB, equal to slot index bit 1.
- B  output  1  decoder select LSB, equal to slot index bit 0.
- G_L  output  1  decoder enable, active low.
- SLOT  output  2  current slot index, equal to {A,B}.
- FRAME  output  1  one-cycle pulse marking the start of a new scan frame after a wrap.

## Operation
- All outputs are registered. Reset values are A=0, B=0, SLOT=0, G_L=1, FRAME=0, and the state machine is in IDLE.
- Slot mapping: slot n selects decoder output Y_L[n], with A=n[1] and B=n[0].
- **IDLE:** G_L=1; A and B hold their last values.
  - If EN=1 and MASK≠0: load the lowest-numbered enabled slot into A/B, go to BLANK. FRAME stays 0.
- **BLANK:** G_L=1; A/B are stable; the counter runs for BLANK cycles, then the block goes to ACTIVE.
- **ACTIVE:** G_L=0 for DWELL cycles. At the end of the dwell:
  - Select the next enabled slot, searching upward from the current slot+1 and wrapping 3→0.
  - Load it into A/B, set G_L=1, go to BLANK.
  - If the selected index is ≤ the current index (a wrap), FRAME=1 for that cycle.
- Single enabled slot: the selected slot is the same slot, so every dwell counts as a wrap and FRAME pulses once per BLANK+DWELL period.
- MASK is sampled only at slot-selection points (the IDLE exit and the end of a dwell). Clearing the bit for the current slot mid-dwell does not shorten that dwell.
- MASK=0 at a selection point: go to IDLE with G_L=1; A/B hold.
- EN=0 in any state: go to IDLE on the next edge with G_L=1, aborting any dwell. A/B hold. No FRAME pulse.
- Invariant: A/B change only on an edge at which G_L is 1, or at which G_L goes from 0 to 1. G_L never goes low in the same cycle that A/B change.
- RESET_L low forces the reset values immediately, without waiting for CLK, including mid-ACTIVE.

## Timing
- EN sampled high at edge t (from IDLE): A/B valid and G_L=1 from t. G_L falls at edge t+BLANK and rises at t+BLANK+DWELL.
- Slot period is BLANK+DWELL cycles. Frame period is k·(BLANK+DWELL) cycles, where k is the number of enabled slots.
- FRAME is high during the first BLANK cycle of the wrapped-to slot.
- EN deassertion: G_L is high one edge later; worst-case extra G_L low time is one cycle.
- Reset release: the first EN sample is on the first rising edge with RESET_L high.

## Test plan
All scenarios use DWELL=4, BLANK=1.
- **Full scan:** reset, MASK=4'b1111, EN=1 → slots 0,1,2,3,0 in order. G_L low exactly 4 cycles per slot, 1 cycle high between slots. FRAME pulses only on the 3→0 transition, every 20 cycles.
- **Masked scan:** MASK=4'b1010 → slots alternate 1,3,1. Each period is 5 cycles. FRAME pulses on each 3→1 transition, every 10 cycles. No G_L low for slots 0 or 2.
- **Single slot:** MASK=4'b0100 → A=1, B=0 constant. G_L pattern is 1,0,0,0,0 repeating. FRAME pulses every 5 cycles.
- **Glitch-free check:** across all scenarios, assert A/B never change while G_L=0, and G_L never falls in the cycle A/B change.
- **Abort and MASK edge cases:**
  - Drop EN in dwell cycle 2 → G_L=1 on the next edge, A/B held, FRAME=0.
  - Re-raise EN → restart at the lowest enabled slot.
  - Set MASK=0 mid-dwell → the dwell completes, then IDLE.
- **Async reset:** pull RESET_L low mid-ACTIVE between clock edges → G_L=1, A=B=0, FRAME=0 immediately. After release with EN=1, the first G_L low occurs BLANK+1 edges later.
